// File: rtl/hex_entry_pkg.sv
// Shared constants and helpers for the pushbutton hex entry block and
// other board-level UI logic built on the DE2-70 keys.
package hex_entry_pkg;

    localparam int KEY_INC    = 0;
    localparam int KEY_DEC    = 1;
    localparam int KEY_CUR    = 2;
    localparam int KEY_COMMIT = 3;
    localparam int NUM_KEYS   = 4;

    localparam int NUM_DIGITS = 8;

    // 10 ms debounce and ~0.25 s blink half-period at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_BLINK_CYCLES    = 12500000;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_LOAD,
        ACT_COMMIT,
        ACT_CURSOR,
        ACT_INC,
        ACT_DEC
    } action_e;

    function automatic logic [3:0] nibble_step(input logic [3:0] nib, input logic down);
        return down ? (nib - 4'd1) : (nib + 4'd1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchroniser, stability counter, and a single-cycle
// pulse on each debounced press (release is silent).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          pressed_reg;
    logic          pressed_dly_reg;
    logic          press_reg;
    logic [CW-1:0] cnt_reg;
    logic          mismatch;

    // synchronised level is active-low, debounced state is active-high
    assign mismatch = (~sync2_reg) != pressed_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg       <= 1'b1;
            sync2_reg       <= 1'b1;
            pressed_reg     <= 1'b0;
            pressed_dly_reg <= 1'b0;
            press_reg       <= 1'b0;
            cnt_reg         <= '0;
        end else begin
            sync1_reg       <= key_n;
            sync2_reg       <= sync1_reg;
            pressed_dly_reg <= pressed_reg;
            press_reg       <= pressed_reg & ~pressed_dly_reg;
            if (!mismatch) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                cnt_reg     <= '0;
                pressed_reg <= ~pressed_reg;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/hex_entry_ctrl.sv
// Pushbutton-driven 8-digit hex editor: arbitrates key/load events, edits the
// nibble under the cursor, blinks that digit and latches committed values.
module hex_entry_ctrl
    import hex_entry_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int          BLINK_CYCLES    = DEFAULT_BLINK_CYCLES,
    parameter logic [31:0] RESET_VALUE     = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_KEYS-1:0]   key_n,
    input  logic                  load_valid,
    input  logic [31:0]           load_value,
    output logic [31:0]           value,
    output logic [NUM_DIGITS-1:0] enable,
    output logic [2:0]            cursor,
    output logic [31:0]           commit_value,
    output logic                  commit_valid
);

    localparam int BW = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    logic [NUM_KEYS-1:0] press;
    action_e             action;

    logic [31:0]           value_reg,        value_next;
    logic [2:0]            cursor_reg,       cursor_next;
    logic [31:0]           commit_value_reg, commit_value_next;
    logic                  commit_valid_reg, commit_valid_next;
    logic [BW-1:0]         blink_cnt_reg,    blink_cnt_next;
    logic                  phase_reg,        phase_next;
    logic [NUM_DIGITS-1:0] enable_reg,       enable_next;
    logic [3:0]            nib;
    logic                  restart;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key (
                .clk   (clk),
                .reset (reset),
                .key_n (key_n[gi]),
                .press (press[gi])
            );
        end
    endgenerate

    // Only the highest-priority event of the cycle acts; the rest are dropped
    always_comb begin
        action = ACT_NONE;
        if (load_valid)               action = ACT_LOAD;
        else if (press[KEY_COMMIT])   action = ACT_COMMIT;
        else if (press[KEY_CUR])      action = ACT_CURSOR;
        else if (press[KEY_INC])      action = ACT_INC;
        else if (press[KEY_DEC])      action = ACT_DEC;
    end

    always_comb begin
        value_next        = value_reg;
        cursor_next       = cursor_reg;
        commit_value_next = commit_value_reg;
        commit_valid_next = 1'b0;
        restart           = 1'b0;
        nib               = value_reg[{cursor_reg, 2'b00} +: 4];

        if (blink_cnt_reg == BLINK_MAX) begin
            blink_cnt_next = '0;
            phase_next     = ~phase_reg;
        end else begin
            blink_cnt_next = blink_cnt_reg + BW'(1);
            phase_next     = phase_reg;
        end

        case (action)
            ACT_LOAD: begin
                value_next  = load_value;
                cursor_next = 3'd0;
                restart     = 1'b1;
            end
            ACT_COMMIT: begin
                commit_value_next = value_reg;
                commit_valid_next = 1'b1;
            end
            ACT_CURSOR: begin
                cursor_next = cursor_reg + 3'd1;
                restart     = 1'b1;
            end
            ACT_INC: begin
                value_next[{cursor_reg, 2'b00} +: 4] = nibble_step(nib, 1'b0);
                restart = 1'b1;
            end
            ACT_DEC: begin
                value_next[{cursor_reg, 2'b00} +: 4] = nibble_step(nib, 1'b1);
                restart = 1'b1;
            end
            default: ;
        endcase

        // an edited digit is shown solid for a full half-period
        if (restart) begin
            blink_cnt_next = '0;
            phase_next     = 1'b1;
        end

        enable_next              = '1;
        enable_next[cursor_next] = phase_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg        <= RESET_VALUE;
            cursor_reg       <= 3'd0;
            commit_value_reg <= RESET_VALUE;
            commit_valid_reg <= 1'b0;
            blink_cnt_reg    <= '0;
            phase_reg        <= 1'b1;
            enable_reg       <= '1;
        end else begin
            value_reg        <= value_next;
            cursor_reg       <= cursor_next;
            commit_value_reg <= commit_value_next;
            commit_valid_reg <= commit_valid_next;
            blink_cnt_reg    <= blink_cnt_next;
            phase_reg        <= phase_next;
            enable_reg       <= enable_next;
        end
    end

    assign value        = value_reg;
    assign cursor       = cursor_reg;
    assign enable       = enable_reg;
    assign commit_value = commit_value_reg;
    assign commit_valid = commit_valid_reg;

endmodule

// File: doc/hex_entry_ctrl.md
# hex_entry_ctrl

Interactive hex value editor driven by the four DE2-70 pushbuttons; it produces the `value`/`enable` pair that feeds the 7-segment display driver, with the digit under edit blinking. Software-free debug entry of 32-bit addresses and data (e.g. PPU/CPU memory peek) sits on top of it: the operator edits digits, then commits, and `commit_value`/`commit_valid` go to the debug logic. Contains per-key synchronisation and debouncing, cursor and blink counters, and a load path for external preset.

## Interface
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); must be at least 2.
- `BLINK_CYCLES`, 12500000: half-period of cursor blink in clk cycles; must be at least 2.
- `RESET_VALUE`, 32'h0000_0000: value and commit_value after reset.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `key_n` in 4: raw DE2 pushbuttons, active-low, asynchronous. `key_n[0]` increments, `key_n[1]` decrements, `key_n[2]` moves the cursor, `key_n[3]` commits.
- `load_valid` in 1: one-cycle strobe that presets the edit value.
- `load_value` in 32: preset data, sampled when `load_valid=1`.
- `value` out 32: current edit value, to the display driver.
- `enable` out 8: digit enables, to the display driver.
- `cursor` out 3: index of the digit under edit (0 = HEX0, rightmost).
- `commit_value` out 32: last committed value, held until the next commit.
- `commit_valid` out 1: one-cycle pulse when `commit_value` updates.

## Operation
- **Key path** (per key, identical):
  - 2-flop synchroniser; both flops reset to 1 (released).
  - Debounce counter compares the synchronised level against the debounced state.
  - On mismatch the counter increments; on match it clears to 0.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still mismatched, the debounced state flips and the counter clears.
  - A press event is a 1-cycle pulse on the debounced released→pressed transition. Release produces no event. There is no auto-repeat.
- **Event arbitration:** all events are evaluated in the same cycle.
  - Priority: `load_valid` > commit > cursor > inc > dec. Only the winner acts; the losing events are dropped.
- **Inc/dec:** 4-bit modular arithmetic on nibble `value[4*cursor+3 : 4*cursor]` (F+1=0, 0-1=F). Other nibbles are unchanged.
- **Cursor:** `cursor <= cursor+1` modulo 8, so 7 wraps to 0.
- **Commit:** `commit_value <= value` and `commit_valid=1` for exactly one cycle; `value` is unchanged.
- **Load:** `value <= load_value`, `cursor <= 0`; no commit pulse.
- **Blink:**
  - The counter runs 0..BLINK_CYCLES-1; at the wrap, `phase` toggles.
  - `enable = 8'hFF` with bit `cursor` forced to `phase`.
  - Any accepted inc/dec/cursor/load clears the counter and sets `phase=1`, so the edited digit is visible immediately.
- **Reset values:**
  - `value=RESET_VALUE`, `commit_value=RESET_VALUE`, `commit_valid=0`, `cursor=0`, `enable=8'hFF`.
  - Internally: `phase=1`, counters 0, debounced states released.
- **Key held through reset:** once the reset deasserts, the press is seen as a new press after the debounce time. This is intended.
- **Reset mid-debounce:** the partial count is discarded.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Key latency:
  - Raw `key_n` falls at cycle 0 and stays low.
  - Debounced state flips at cycle 2+DEBOUNCE_CYCLES.
  - Press event asserts at cycle 3+DEBOUNCE_CYCLES.
  - `value`/`cursor`/`commit_*` update at cycle 4+DEBOUNCE_CYCLES.
- Bounce shorter than DEBOUNCE_CYCLES produces no event.
- `load_valid` in cycle N updates `value`/`cursor` at N+1, and that cycle's key events are dropped.
- `enable` follows `cursor`/`phase` with one cycle of registering. A cursor move updates `cursor` and `enable` in the same cycle.
- `commit_valid` never asserts in two consecutive cycles, because one press event is 1 cycle wide and the next press needs a full debounce.

## Structure
- **Shared package `hex_entry_pkg`:**
  - Key index constants `KEY_INC=0`, `KEY_DEC=1`, `KEY_CUR=2`, `KEY_COMMIT=3`.
  - `NUM_DIGITS=8`.
  - Debounce/blink default constants, also reused by other board-level UI blocks.
- **Sub-module `key_debounce`:** synchroniser, debounce counter, and press pulse, with parameter DEBOUNCE_CYCLES, instantiated 4 times.
- **Top level:** arbitration, nibble update, cursor, blink and commit registers.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, BLINK_CYCLES=8.
- **Reset:** assert `reset` 3 cycles. Expect `value=0`, `cursor=0`, `enable=FF`, `commit_valid=0`. Then, with no keys, `enable[0]` toggles every 8 cycles and other bits stay 1.
- **Increment and wrap:** press `key_n[0]` 16 times (each low 10 and high 10 cycles). Expect `value[3:0]` to step 1..F then 0. Bouncing 1-low/1-high for 3 cycles before each press gives exactly one step per press.
- **Cursor wrap and decrement:** press cursor 3 times then dec once. Expect `cursor=3` and `value=32'h0000_F000`; 5 more cursor presses give `cursor=0`. After each move the new cursor's enable bit is 1 for 8 cycles.
- **Commit:** with `value=32'h1234_ABCD`, press `key_n[3]`. Expect `commit_valid` high for exactly 1 cycle at 4+DEBOUNCE_CYCLES (=8) cycles after the falling edge of `key_n[3]`, with `commit_value=32'h1234_ABCD`, and `value` unchanged.
- **Load priority:** `load_valid` with `load_value=32'hDEAD_BEEF` in the same cycle as an inc press event. Expect `value=DEADBEEF`, `cursor=0`, and no increment.
- **Reset mid-operation:** hold `key_n[0]` low, assert `reset` at debounce count 2, and keep the key low. Expect no event until 4+DEBOUNCE_CYCLES (=8) cycles after reset deasserts, then exactly one increment (`value=1`).
